// File: rtl/dds_pipe_reg.sv
// Clock-enabled WIDTH x DEPTH delay pipe with valid tracking, flush and occupancy.
// Define RESET_DATA_EN to make CLRbar also clear the data stages.
module dds_pipe_reg #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             CLRbar,
  input  logic             CE,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             D_VALID,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic [OCC_W-1:0] OCC
);

  logic [WIDTH-1:0] r_stg [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [OCC_W-1:0] r_occ;
  logic             w_shift;
  logic [OCC_W-1:0] w_occ_nxt;

  assign w_shift   = CE & ~FLUSH;
  assign w_occ_nxt = r_occ + OCC_W'(D_VALID)
                   - OCC_W'(r_vld[DEPTH-1]);

  always_ff @(posedge CLK or posedge CLRbar) begin
    if (CLRbar) begin
      r_vld <= '0;
      r_occ <= '0;
    end else if (FLUSH) begin
      r_vld <= '0;
      r_occ <= '0;
    end else if (CE) begin
      r_vld <= (r_vld << 1) | DEPTH'(D_VALID);
      r_occ <= w_occ_nxt;
    end
  end

`ifdef RESET_DATA_EN
  always_ff @(posedge CLK or posedge CLRbar) begin
    if (CLRbar) begin
      for (int i = 0; i < DEPTH; i++)
        r_stg[i] <= '0;
    end else if (w_shift) begin
      r_stg[0] <= D_IN;
      for (int i = 1; i < DEPTH; i++)
        r_stg[i] <= r_stg[i-1];
    end
  end
`else
  // No reset on data; hold while CLRbar is high so Q keeps its last word
  always_ff @(posedge CLK) begin
    if (w_shift && !CLRbar) begin
      r_stg[0] <= D_IN;
      for (int i = 1; i < DEPTH; i++)
        r_stg[i] <= r_stg[i-1];
    end
  end
`endif

  assign Q       = r_stg[DEPTH-1];
  assign Q_VALID = r_vld[DEPTH-1];
  assign OCC     = r_occ;

endmodule

// File: tb/tb_dds_pipe_reg.sv
// Directed bench for dds_pipe_reg: DEPTH=4 instance plus a DEPTH=1 instance.
// Expected values are hand-computed tables.
module tb_dds_pipe_reg;

  logic       clk = 1'b0;
  logic       clr, ce, flush, dv;
  logic [7:0] din, q;
  logic       qv;
  logic [2:0] occ;
  logic       ce1, dv1;
  logic [7:0] din1, q1;
  logic       qv1;
  logic [0:0] occ1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dds_pipe_reg #(.WIDTH(8), .DEPTH(4)) u_dut (
    .CLK(clk), .CLRbar(clr), .CE(ce), .FLUSH(flush),
    .D_IN(din), .D_VALID(dv),
    .Q(q), .Q_VALID(qv), .OCC(occ)
  );

  dds_pipe_reg #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .CLK(clk), .CLRbar(clr), .CE(ce1), .FLUSH(flush),
    .D_IN(din1), .D_VALID(dv1),
    .Q(q1), .Q_VALID(qv1), .OCC(occ1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (qv !== 1'b0 || occ !== 3'd0) begin
      $display("FAIL reset4 qv=%b occ=%0d want qv=0 occ=0", qv, occ);
      bad++;
    end
    total++;
    if (qv1 !== 1'b0 || occ1 !== 1'b0) begin
      $display("FAIL reset1 qv=%b occ=%0d want qv=0 occ=0", qv1, occ1);
      bad++;
    end
    step();
    step();
    clr = 1'b0;
  endtask

  task automatic test_latency();
    logic [2:0] exp_occ [5] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    logic       exp_qv  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ce = 1'b1; din = 8'hA5; dv = 1'b1;
    for (int e = 0; e < 5; e++) begin
      step();
      dv = 1'b0; din = 8'h00;
      total++;
      if (occ !== exp_occ[e] || qv !== exp_qv[e]) begin
        $display("FAIL latency edge%0d occ=%0d qv=%b want occ=%0d qv=%b",
                 e + 1, occ, qv, exp_occ[e], exp_qv[e]);
        bad++;
      end
      if (exp_qv[e]) begin
        total++;
        if (q !== 8'hA5) begin
          $display("FAIL latency_data q=%h want a5", q);
          bad++;
        end
      end
    end
  endtask

  task automatic test_stall();
    logic       ce_pat  [12] = '{1,1,1,0,0,1,1,1,1,1,1,1};
    logic [7:0] din_pat [12] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h04,
                                 8'h05, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00};
    logic       dv_pat  [12] = '{1,1,1,1,1,1,1,1,0,0,0,0};
    logic [2:0] exp_occ [12] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4,
                                 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic       exp_qv  [12] = '{0,0,0,0,0,1,1,1,1,1,1,0};
    logic [7:0] exp_q   [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
                                 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00};
    for (int e = 0; e < 12; e++) begin
      ce = ce_pat[e]; din = din_pat[e]; dv = dv_pat[e];
      step();
      total++;
      if (occ !== exp_occ[e] || qv !== exp_qv[e]) begin
        $display("FAIL stall edge%0d occ=%0d qv=%b want occ=%0d qv=%b",
                 e + 1, occ, qv, exp_occ[e], exp_qv[e]);
        bad++;
      end
      if (exp_qv[e]) begin
        total++;
        if (q !== exp_q[e]) begin
          $display("FAIL stall_data edge%0d q=%h want %h", e + 1, q, exp_q[e]);
          bad++;
        end
      end
    end
    ce = 1'b1; dv = 1'b0;
  endtask

  task automatic test_full();
    logic [2:0] exp_occ;
    ce = 1'b1; dv = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      din = 8'h10 + 8'(k);
      step();
      exp_occ = (k < 4) ? 3'(k) : 3'd4;
      total++;
      if (occ !== exp_occ) begin
        $display("FAIL full_occ edge%0d occ=%0d want %0d", k, occ, exp_occ);
        bad++;
      end
      if (k >= 4) begin
        total++;
        if (qv !== 1'b1 || q !== 8'h10 + 8'(k - 3)) begin
          $display("FAIL full_data edge%0d q=%h qv=%b want %h qv=1",
                   k, q, qv, 8'h10 + 8'(k - 3));
          bad++;
        end
      end
    end
  endtask

  task automatic test_flush();
    dv = 1'b0; din = 8'h00;
    step();
    total++;
    if (occ !== 3'd3) begin
      $display("FAIL flush_pre occ=%0d want 3", occ);
      bad++;
    end
    flush = 1'b1; ce = 1'b1; dv = 1'b1; din = 8'h77;
    step();
    flush = 1'b0; dv = 1'b0; din = 8'h00;
    total++;
    if (occ !== 3'd0 || qv !== 1'b0) begin
      $display("FAIL flush occ=%0d qv=%b want occ=0 qv=0", occ, qv);
      bad++;
    end
    for (int e = 0; e < 5; e++) begin
      step();
      total++;
      if (qv !== 1'b0 || occ !== 3'd0) begin
        $display("FAIL flush_drop edge%0d qv=%b q=%h occ=%0d want qv=0 occ=0",
                 e + 1, qv, q, occ);
        bad++;
      end
    end
  endtask

  task automatic test_async_clear();
    ce = 1'b1; dv = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      din = 8'hC0 + 8'(k);
      step();
    end
    dv = 1'b0; ce = 1'b0;
    total++;
    if (qv !== 1'b1 || q !== 8'hC1 || occ !== 3'd4) begin
      $display("FAIL preclr q=%h qv=%b occ=%0d want c1 1 4", q, qv, occ);
      bad++;
    end
    #2 clr = 1'b1;
    #1;
    total++;
    if (qv !== 1'b0 || occ !== 3'd0) begin
      $display("FAIL async_clr qv=%b occ=%0d want qv=0 occ=0", qv, occ);
      bad++;
    end
    total++;
`ifdef RESET_DATA_EN
    if (q !== 8'h00) begin
      $display("FAIL async_clr_data q=%h want 00", q);
      bad++;
    end
`else
    if (q !== 8'hC1) begin
      $display("FAIL async_clr_data q=%h want c1", q);
      bad++;
    end
`endif
    step();
    clr = 1'b0;
    ce = 1'b1; dv = 1'b1; din = 8'h5A;
    step();
    dv = 1'b0;
    total++;
    if (occ !== 3'd1 || qv !== 1'b0) begin
      $display("FAIL post_clr occ=%0d qv=%b want occ=1 qv=0", occ, qv);
      bad++;
    end
    for (int e = 0; e < 4; e++) step();
    total++;
    if (occ !== 3'd0 || qv !== 1'b0) begin
      $display("FAIL post_clr_drain occ=%0d qv=%b want 0 0", occ, qv);
      bad++;
    end
  endtask

  task automatic test_depth1();
    ce1 = 1'b1; din1 = 8'h3C; dv1 = 1'b1;
    step();
    total++;
    if (q1 !== 8'h3C || qv1 !== 1'b1 || occ1 !== 1'b1) begin
      $display("FAIL d1_load q=%h qv=%b occ=%0d want 3c 1 1", q1, qv1, occ1);
      bad++;
    end
    din1 = 8'h4D;
    step();
    total++;
    if (q1 !== 8'h4D || qv1 !== 1'b1 || occ1 !== 1'b1) begin
      $display("FAIL d1_b2b q=%h qv=%b occ=%0d want 4d 1 1", q1, qv1, occ1);
      bad++;
    end
    dv1 = 1'b0;
    step();
    total++;
    if (qv1 !== 1'b0 || occ1 !== 1'b0) begin
      $display("FAIL d1_drain qv=%b occ=%0d want 0 0", qv1, occ1);
      bad++;
    end
    ce1 = 1'b0;
  endtask

  initial begin
    clr = 1'b1; ce = 1'b0; flush = 1'b0; dv = 1'b0; din = 8'h00;
    ce1 = 1'b0; dv1 = 1'b0; din1 = 8'h00;
    test_reset();
    test_latency();
    test_stall();
    test_full();
    test_flush();
    test_async_clear();
    test_depth1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
